bsg_manycore_store_fence_ctrl: RTL and testbench
================================================

Name: bsg_manycore_store_fence_ctrl

Overview:
- Sits between the core's remote-store request port and the outbound request network.
- Issues a credit per remote store and counts outstanding stores, decrementing on each store acknowledgement from the return network.
- Throttles issue when credits are exhausted.
- Sequences fence requests: blocks new stores until the outstanding count drains to zero, then pulses completion back to the core.

Parameters:
- x_cord_width_p, "inv", X coordinate width (passed to acknowledgement source check).
- y_cord_width_p, "inv", Y coordinate width.
- max_out_p, 16, maximum outstanding remote stores (credits); must be >= 1.
- cntr_width_lp, $clog2(max_out_p+1), outstanding-counter width (derived).
- timeout_p, 1024, fence timeout in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- st_v_i  in  1  core presents a remote store.
- st_yumi_o  out  1  store taken this cycle (st_v_o & st_ready_i).
- st_v_o  out  1  store valid to network.
- st_ready_i  in  1  network accepts store.
- ret_v_i  in  1  store acknowledgement arriving.
- ret_from_x_i  in  x_cord_width_p  ack source X.
- ret_from_y_i  in  y_cord_width_p  ack source Y.
- my_x_i  in  x_cord_width_p  tile X.
- my_y_i  in  y_cord_width_p  tile Y.
- ret_ready_o  out  1  tied 1; acks always accepted.
- fence_v_i  in  1  core requests fence.
- fence_ready_o  out  1  fence accepted (high only in IDLE).
- fence_done_o  out  1  one-cycle completion pulse.
- out_cnt_o  out  cntr_width_lp  current outstanding count.
- err_underflow_o  out  1  sticky: ack received with count 0.

Behaviour:
- Clock/reset: single clock clk_i. reset_n_i is asynchronous, active-low.
- Reset values: state=IDLE, out_cnt_o=0, err_underflow_o=0, fence_done_o=0, st_v_o=0.
- Reset asserted mid-fence or mid-store aborts immediately: no done pulse, count cleared.
- ret_valid_nl = ret_v_i & ({ret_from_x_i, ret_from_y_i} != {my_x_i, my_y_i}). Self-addressed acks are ignored.
- Credit gate: credit_ok = (out_cnt_o != max_out_p).
- Issue: st_v_o = st_v_i & credit_ok & (state==IDLE). Combinational, zero latency.
- inc = st_v_o & st_ready_i.
- Counter update, next cycle:
  - inc & ~ret_valid_nl: +1.
  - ~inc & ret_valid_nl: -1 if count>0; otherwise hold at 0 and set err_underflow_o.
  - both or neither: hold.
- Full boundary: at count==max_out_p, st_v_o=0. A same-cycle ack does not unblock issue; the freed credit is visible next cycle.
- Counter never exceeds max_out_p and never wraps.
- FSM:
  - IDLE:
    - fence_ready_o=1. Stores pass subject to credit.
    - fence_v_i -> FENCE. A store issued in the same cycle is counted before the drain check.
  - FENCE:
    - st_v_o=0; fence_ready_o=0.
    - When out_cnt_o==0 and no inc this cycle -> DONE. Entry with count already 0 still spends one cycle in FENCE.
  - DONE:
    - fence_done_o=1 for exactly one cycle -> IDLE.
    - Stores are still blocked in DONE.
- Minimum fence latency: fence_v_i in cycle N gives fence_done_o in cycle N+2.
- fence_v_i outside IDLE is ignored (not accepted).
- Acks continue to be counted in all states.

Optional Feature:
- Macro: BSG_MANYCORE_FENCE_TIMEOUT_EN.
- With macro defined:
  - Adds a timeout counter of width $clog2(timeout_p+1), cleared on FENCE entry and incremented each FENCE cycle.
  - On reaching timeout_p: adds output port fence_timeout_o (sticky, cleared only by reset) and issues $display("fence timeout x%x y%x cnt%d") once.
  - The FSM keeps waiting; it does not force DONE.
- Without macro: no timeout counter, no fence_timeout_o port, no timeout message.

Test Plan:
- Credit exhaustion (max_out_p=4): st_v_i=1, st_ready_i=1, no acks for 6 cycles -> 4 yumis, out_cnt_o=4, st_v_o=0 from cycle 5. One ack -> out_cnt_o=3, issue resumes the following cycle.
- Simultaneous issue+ack at count=2 -> count stays 2.
- Self-addressed ack (ret_from == my coords) -> count unchanged.
- Empty fence: count=0, fence_v_i pulse at cycle 10 -> FENCE at 11, fence_done_o high only at cycle 12, IDLE at 13.
- Draining fence: count=3, fence at cycle 0, acks at cycles 4, 7, 9 -> st_v_o=0 throughout, fence_done_o at cycle 11.
- Underflow: count=0, nonlocal ack -> count stays 0, err_underflow_o=1 and stays 1 until reset_n_i low.
- Async reset mid-FENCE with count=2: reset_n_i low between clock edges -> out_cnt_o=0 and state IDLE immediately, fence_done_o never pulses.
- With BSG_MANYCORE_FENCE_TIMEOUT_EN and timeout_p=8: fence with count=1 and no acks -> fence_timeout_o=1 after 8 FENCE cycles. A late ack then gives fence_done_o, and fence_timeout_o stays 1.

Source files
------------

// File: rtl/bsg_manycore_store_fence_ctrl.sv
// Remote-store credit counter and fence sequencer between the core and the request network.
// Optional fence watchdog enabled by defining BSG_MANYCORE_FENCE_TIMEOUT_EN.
module bsg_manycore_store_fence_ctrl #(
    parameter int unsigned x_cord_width_p = 4,
    parameter int unsigned y_cord_width_p = 4,
    parameter int unsigned max_out_p      = 16,
    parameter int unsigned cntr_width_lp  = $clog2(max_out_p + 1),
    parameter int unsigned timeout_p      = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic                      st_v_i,
    output logic                      st_yumi_o,
    output logic                      st_v_o,
    input  logic                      st_ready_i,

    input  logic                      ret_v_i,
    input  logic [x_cord_width_p-1:0] ret_from_x_i,
    input  logic [y_cord_width_p-1:0] ret_from_y_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    output logic                      ret_ready_o,

    input  logic                      fence_v_i,
    output logic                      fence_ready_o,
    output logic                      fence_done_o,
`ifdef BSG_MANYCORE_FENCE_TIMEOUT_EN
    output logic                      fence_timeout_o,
`endif
    output logic [cntr_width_lp-1:0]  out_cnt_o,
    output logic                      err_underflow_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FENCE = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                   state_r;
    logic [cntr_width_lp-1:0] cnt_r;
    logic                     err_r;
    logic                     ret_valid_nl;
    logic                     credit_ok;
    logic                     inc;

    // Acks that loop back from our own tile never correspond to a counted store.
    assign ret_valid_nl = ret_v_i & ({ret_from_x_i, ret_from_y_i} != {my_x_i, my_y_i});
    assign credit_ok    = (cnt_r != cntr_width_lp'(max_out_p));

    assign st_v_o          = st_v_i & credit_ok & (state_r == IDLE);
    assign st_yumi_o       = st_v_o & st_ready_i;
    assign inc             = st_yumi_o;
    assign ret_ready_o     = 1'b1;
    assign fence_ready_o   = (state_r == IDLE);
    assign fence_done_o    = (state_r == DONE);
    assign out_cnt_o       = cnt_r;
    assign err_underflow_o = err_r;

    // Outstanding counter, sticky underflow flag and fence sequencing.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            if (inc && !ret_valid_nl) begin
                cnt_r <= cnt_r + cntr_width_lp'(1);
            end else if (!inc && ret_valid_nl) begin
                if (cnt_r != '0) begin
                    cnt_r <= cnt_r - cntr_width_lp'(1);
                end else begin
                    err_r <= 1'b1;
                end
            end

            case (state_r)
                IDLE:    if (fence_v_i) state_r <= FENCE;
                FENCE:   if ((cnt_r == '0) && !inc) state_r <= DONE;
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef BSG_MANYCORE_FENCE_TIMEOUT_EN
    localparam int unsigned tmo_width_lp = $clog2(timeout_p + 1);

    logic [tmo_width_lp-1:0] tmo_cnt_r;
    logic                    tmo_r;

    assign fence_timeout_o = tmo_r;

    // Watchdog only reports a stuck fence; it never forces completion.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tmo_cnt_r <= '0;
            tmo_r     <= 1'b0;
        end else if ((state_r == IDLE) && fence_v_i) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == FENCE) && (tmo_cnt_r != tmo_width_lp'(timeout_p))) begin
            tmo_cnt_r <= tmo_cnt_r + tmo_width_lp'(1);
            if (tmo_cnt_r == tmo_width_lp'(timeout_p - 1)) begin
                tmo_r <= 1'b1;
                if (!tmo_r) begin
                    $display("fence timeout x%x y%x cnt%d", my_x_i, my_y_i, cnt_r);
                end
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (timeout_p == 0);
`endif

endmodule

// File: tb/tb_bsg_manycore_store_fence_ctrl.sv
// Directed-vector scoreboard bench for bsg_manycore_store_fence_ctrl (max_out_p=4, timeout_p=8).
module tb_bsg_manycore_store_fence_ctrl;

    localparam int unsigned XW = 4;
    localparam int unsigned YW = 4;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          st_v_i = 1'b0, st_ready_i = 1'b0, ret_v_i = 1'b0, fence_v_i = 1'b0;
    logic [XW-1:0] ret_from_x_i = 4'd2, my_x_i = 4'd3;
    logic [YW-1:0] ret_from_y_i = 4'd5, my_y_i = 4'd5;
    logic          st_yumi_o, st_v_o, ret_ready_o, fence_ready_o, fence_done_o, err_underflow_o;
    logic [CW-1:0] out_cnt_o;
    logic          fence_timeout;

    bsg_manycore_store_fence_ctrl #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .max_out_p(4), .timeout_p(8)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .st_v_i(st_v_i), .st_yumi_o(st_yumi_o), .st_v_o(st_v_o), .st_ready_i(st_ready_i),
        .ret_v_i(ret_v_i), .ret_from_x_i(ret_from_x_i), .ret_from_y_i(ret_from_y_i),
        .my_x_i(my_x_i), .my_y_i(my_y_i), .ret_ready_o(ret_ready_o),
        .fence_v_i(fence_v_i), .fence_ready_o(fence_ready_o), .fence_done_o(fence_done_o),
`ifdef BSG_MANYCORE_FENCE_TIMEOUT_EN
        .fence_timeout_o(fence_timeout),
`endif
        .out_cnt_o(out_cnt_o), .err_underflow_o(err_underflow_o)
    );

`ifndef BSG_MANYCORE_FENCE_TIMEOUT_EN
    assign fence_timeout = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        int            tag;
        logic [4:0]    ex;      // {st_v_o, st_yumi_o, fence_ready_o, fence_done_o, err_underflow_o}
        logic [CW-1:0] cnt;
        logic          chk_to;
        logic          to;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tag   = 0;
    logic chk_to_g = 1'b0;
    logic exp_to_g = 1'b0;

    task automatic cmp(input int t, input string what, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL vec%0d %s got %0h want %0h", t, what, got, want);
        end
    endtask

    task automatic push(input logic [4:0] ex, input logic [CW-1:0] cnt);
        exp_t e;
        e.tag = tag; e.ex = ex; e.cnt = cnt; e.chk_to = chk_to_g; e.to = exp_to_g;
        q.push_back(e);
        tag++;
    endtask

    // in = {st_v_i, st_ready_i, ret_v_i, ret_self, fence_v_i}; ex/cnt = outputs during this cycle
    task automatic step(input logic [4:0] in, input logic [4:0] ex, input logic [CW-1:0] cnt);
        @(posedge clk);
        #1;
        st_v_i       = in[4];
        st_ready_i   = in[3];
        ret_v_i      = in[2];
        ret_from_x_i = in[1] ? my_x_i : 4'd2;
        fence_v_i    = in[0];
        push(ex, cnt);
    endtask

    // Monitor: one expected record per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.tag, "st_v_o",          8'(st_v_o),          8'(e.ex[4]));
            cmp(e.tag, "st_yumi_o",       8'(st_yumi_o),       8'(e.ex[3]));
            cmp(e.tag, "fence_ready_o",   8'(fence_ready_o),   8'(e.ex[2]));
            cmp(e.tag, "fence_done_o",    8'(fence_done_o),    8'(e.ex[1]));
            cmp(e.tag, "err_underflow_o", 8'(err_underflow_o), 8'(e.ex[0]));
            cmp(e.tag, "out_cnt_o",       8'(out_cnt_o),       8'(e.cnt));
            cmp(e.tag, "ret_ready_o",     8'(ret_ready_o),     8'(1));
            if (e.chk_to) cmp(e.tag, "fence_timeout_o", 8'(fence_timeout), 8'(e.to));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        step(5'b00000, 5'b00100, 0);
        #6 reset_n = 1'b1;

        // credit exhaustion and same-cycle ack at full
        step(5'b11000, 5'b11100, 0);
        step(5'b11000, 5'b11100, 1);
        step(5'b11000, 5'b11100, 2);
        step(5'b11000, 5'b11100, 3);
        step(5'b11000, 5'b00100, 4);
        step(5'b11000, 5'b00100, 4);
        step(5'b11100, 5'b00100, 4);
        step(5'b11000, 5'b11100, 3);
        step(5'b00100, 5'b00100, 4);
        step(5'b00100, 5'b00100, 3);
        // simultaneous issue+ack, network stall, self-addressed ack
        step(5'b11100, 5'b11100, 2);
        step(5'b10000, 5'b10100, 2);
        step(5'b00110, 5'b00100, 2);
        step(5'b11000, 5'b11100, 2);

        // draining fence from count 3, acks at relative cycles 4, 7, 9
        step(5'b00001, 5'b00100, 3);
        step(5'b11000, 5'b00000, 3);
        step(5'b11000, 5'b00000, 3);
        step(5'b11000, 5'b00000, 3);
        step(5'b11100, 5'b00000, 3);
        step(5'b11001, 5'b00000, 2);
        step(5'b11000, 5'b00000, 2);
        step(5'b11100, 5'b00000, 2);
        step(5'b11000, 5'b00000, 1);
        step(5'b11100, 5'b00000, 1);
        step(5'b11000, 5'b00000, 0);
        step(5'b11001, 5'b00010, 0);
        step(5'b00000, 5'b00100, 0);

        // empty fence: done exactly two cycles after request
        step(5'b00001, 5'b00100, 0);
        step(5'b11000, 5'b00000, 0);
        step(5'b11000, 5'b00010, 0);
        step(5'b00000, 5'b00100, 0);

        // store issued in the fence cycle is counted before draining
        step(5'b11001, 5'b11100, 0);
        step(5'b11100, 5'b00000, 1);
        step(5'b00000, 5'b00000, 0);
        step(5'b00000, 5'b00010, 0);
        step(5'b00000, 5'b00100, 0);

        // underflow: self ack at zero is harmless, nonlocal ack sets sticky flag
        step(5'b00110, 5'b00100, 0);
        step(5'b00100, 5'b00100, 0);
        step(5'b00000, 5'b00101, 0);
        step(5'b11000, 5'b11101, 0);
        step(5'b11000, 5'b11101, 1);
        step(5'b00001, 5'b00101, 2);
        step(5'b00000, 5'b00001, 2);

        // async reset between edges while fencing with count 2
        @(posedge clk);
        #2 reset_n = 1'b0;
        push(5'b00100, 0);
        step(5'b00000, 5'b00100, 0);
        step(5'b00000, 5'b00100, 0);
        #6 reset_n = 1'b1;
        step(5'b00000, 5'b00100, 0);
        step(5'b00000, 5'b00100, 0);
        step(5'b00000, 5'b00100, 0);

`ifdef BSG_MANYCORE_FENCE_TIMEOUT_EN
        // watchdog flags after 8 fence cycles, fence still completes on a late ack
        chk_to_g = 1'b1;
        exp_to_g = 1'b0;
        step(5'b11000, 5'b11100, 0);
        step(5'b00001, 5'b00100, 1);
        for (int i = 0; i < 8; i++) step(5'b00000, 5'b00000, 1);
        exp_to_g = 1'b1;
        step(5'b00100, 5'b00000, 1);
        step(5'b00000, 5'b00000, 0);
        step(5'b00000, 5'b00010, 0);
        step(5'b00000, 5'b00100, 0);
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain queue left %0d want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
